// File: rtl/timebase_pkg.sv
// Shared types and constants for the timebase scheduler and its counter stages.
package timebase_pkg;

  // Baud-divisor configuration FSM: IDLE accepts a divisor, PENDING waits for
  // the running baud period to finish before applying it.
  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_t;

  // 50 MHz / (6 * 9600): 6x oversampled 9600 baud.
  localparam int BAUD_DIV_RST_DEFAULT = 868;

  // Clock cycles per tick strobe; CLK_HZ must be an exact multiple of TICK_HZ.
  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Counter width able to hold 0..max-1, never narrower than one bit.
  function automatic int cnt_width(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

endpackage

// File: rtl/timebase_if.sv
// Baud-divisor configuration bus between a host and the timebase scheduler.
//
// Handshake: a transfer happens on a rising clk_i edge where cfg_valid_i and
// cfg_ready_o are both high. cfg_div_i is sampled only on that edge. The host
// holds cfg_valid_i and cfg_div_i stable until the transfer happens; the
// scheduler may hold cfg_ready_o low for as long as a divisor is pending.
interface timebase_if #(
  parameter int DIV_W = 16
) ();

  logic             cfg_valid_i;
  logic [DIV_W-1:0] cfg_div_i;
  logic             cfg_ready_o;
  logic             cfg_err_o;
  logic [DIV_W-1:0] cur_div_o;

  modport master (
    output cfg_valid_i,
    output cfg_div_i,
    input  cfg_ready_o,
    input  cfg_err_o,
    input  cur_div_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_div_i,
    output cfg_ready_o,
    output cfg_err_o,
    output cur_div_o
  );

endinterface

// File: rtl/timebase_strobe_counter.sv
// Fixed-modulus counter: counts 0..MAX-1 on enabled cycles and emits a
// registered one-cycle strobe on the wrap edge. i_clr restarts the count and
// takes priority over a simultaneous wrap.
module strobe_counter
  import timebase_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_en,
  input  logic i_clr,
  output logic o_last,
  output logic o_wrap
);

  localparam int            CW   = cnt_width(MAX);
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] r_cnt;
  logic          r_wrap;

  // o_last lets a following stage count this stage's wraps in the same edge.
  assign o_last = (r_cnt == LAST);
  assign o_wrap = r_wrap;

  // Count, wrap at LAST, strobe only on the wrap edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_wrap <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/timebase_scheduler.sv
// Central timebase: a runtime-programmable baud strobe, a TICK_HZ strobe and
// a 1 Hz strobe, all single-cycle clock enables on clk_i. A new baud divisor
// is taken over the config bus and applied only at a baud period boundary.
module timebase_scheduler
  import timebase_pkg::*;
#(
  parameter int CLK_HZ        = 50000000,
  parameter int TICK_HZ       = 1000,
  parameter int TICKS_PER_SEC = 1000,
  parameter int DIV_W         = 16,
  parameter int BAUD_DIV_RST  = BAUD_DIV_RST_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        sync_i,
  timebase_if.slave   cfg,
  output logic        baud_tick_o,
  output logic        tick_o,
  output logic        sec_tick_o,
  output cfg_state_t  dbg_state_o
);

  localparam int               TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(BAUD_DIV_RST);

  cfg_state_t       r_state;
  cfg_state_t       w_state_nxt;
  logic             r_cfg_ready;
  logic             r_cfg_err;
  logic [DIV_W-1:0] r_pend_div;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_bcnt;
  logic             r_baud_tick;

  logic w_accept;
  logic w_bwrap;
  logic w_apply;
  logic w_tick_last;
  logic w_tick_wrap;
  logic w_sec_wrap;
  logic w_sec_last_unused;

  assign w_accept = cfg.cfg_valid_i & r_cfg_ready;
  // Enabled edge that closes the current baud period.
  assign w_bwrap  = en_i & (r_bcnt == (r_cur_div - DIV_W'(1)));
  assign w_apply  = (r_state == CFG_PENDING) & w_bwrap;

  assign cfg.cfg_ready_o = r_cfg_ready;
  assign cfg.cfg_err_o   = r_cfg_err;
  assign cfg.cur_div_o   = r_cur_div;
  assign baud_tick_o     = r_baud_tick;
  assign tick_o          = w_tick_wrap;
  assign sec_tick_o      = w_sec_wrap;
  assign dbg_state_o     = r_state;

  // Config FSM next state: accept in IDLE, release at the apply edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CFG_IDLE:    if (w_accept) w_state_nxt = CFG_PENDING;
      CFG_PENDING: if (w_bwrap)  w_state_nxt = CFG_IDLE;
      default:     w_state_nxt = CFG_IDLE;
    endcase
  end

  // Config FSM state register; ready is registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= CFG_IDLE;
      r_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_ready <= (w_state_nxt == CFG_IDLE);
    end
  end

  // Capture an accepted divisor, clamping values below 2 and flagging it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend_div <= DIV_RST;
      r_cfg_err  <= 1'b0;
    end else if (w_accept) begin
      r_pend_div <= (cfg.cfg_div_i < DIV_MIN) ? DIV_MIN : cfg.cfg_div_i;
      r_cfg_err  <= (cfg.cfg_div_i < DIV_MIN);
    end else begin
      r_cfg_err  <= 1'b0;
    end
  end

  // Baud counter; a pending divisor takes effect only on a wrap edge so the
  // outgoing period always runs to its full length.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bcnt      <= '0;
      r_cur_div   <= DIV_RST;
      r_baud_tick <= 1'b0;
    end else if (en_i) begin
      if (w_bwrap) begin
        r_bcnt      <= '0;
        r_baud_tick <= 1'b1;
        if (w_apply) r_cur_div <= r_pend_div;
      end else begin
        r_bcnt      <= r_bcnt + DIV_W'(1);
        r_baud_tick <= 1'b0;
      end
    end else begin
      r_baud_tick <= 1'b0;
    end
  end

  strobe_counter #(
    .MAX (TICK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_en   (en_i),
    .i_clr  (sync_i),
    .o_last (w_tick_last),
    .o_wrap (w_tick_wrap)
  );

  // Seconds stage advances on the same edge the tick stage wraps, so both
  // strobes coincide when the seconds count rolls over.
  strobe_counter #(
    .MAX (TICKS_PER_SEC)
  ) u_sec (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_en   (en_i & w_tick_last),
    .i_clr  (sync_i),
    .o_last (w_sec_last_unused),
    .o_wrap (w_sec_wrap)
  );

endmodule

// File: tb/tb_timebase_scheduler.sv
// Directed bench for timebase_scheduler with a small timebase:
// 20 Hz clock, 4 Hz tick (divide by 5), 4 ticks per second, baud divisor 6.
module tb_timebase_scheduler;
  import timebase_pkg::*;

  logic       clk_i;
  logic       rst_i;
  logic       en_i;
  logic       sync_i;
  logic       baud_tick_o;
  logic       tick_o;
  logic       sec_tick_o;
  cfg_state_t dbg_state_o;

  int n_checks;
  int n_fail;

  timebase_if #(.DIV_W(16)) cfg_bus ();

  timebase_scheduler #(
    .CLK_HZ        (20),
    .TICK_HZ       (4),
    .TICKS_PER_SEC (4),
    .DIV_W         (16),
    .BAUD_DIV_RST  (6)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .sync_i      (sync_i),
    .cfg         (cfg_bus.slave),
    .baud_tick_o (baud_tick_o),
    .tick_o      (tick_o),
    .sec_tick_o  (sec_tick_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Hold reset for two edges, check reset values, release with en_i=1 so the
  // next rising edge is enabled edge 1.
  task automatic do_reset(input string tag);
    rst_i               = 1'b1;
    en_i                = 1'b0;
    sync_i              = 1'b0;
    cfg_bus.cfg_valid_i = 1'b0;
    cfg_bus.cfg_div_i   = '0;
    step();
    step();
    check_eq({tag, "_rst_cur_div"}, 32'(cfg_bus.cur_div_o), 6);
    check_eq({tag, "_rst_ready"},   32'(cfg_bus.cfg_ready_o), 1);
    check_eq({tag, "_rst_strobes"}, {29'd0, baud_tick_o, tick_o, sec_tick_o}, 0);
    check_eq({tag, "_rst_err"},     32'(cfg_bus.cfg_err_o), 0);
    check_eq({tag, "_rst_state"},   32'(dbg_state_o), 32'(CFG_IDLE));
    rst_i = 1'b0;
    en_i  = 1'b1;
  endtask

  task automatic offer(input logic [15:0] div);
    cfg_bus.cfg_valid_i = 1'b1;
    cfg_bus.cfg_div_i   = div;
  endtask

  task automatic drop_offer();
    cfg_bus.cfg_valid_i = 1'b0;
    cfg_bus.cfg_div_i   = 16'hBEEF;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_i    = 1'b1;
    en_i     = 1'b0;
    sync_i   = 1'b0;
    cfg_bus.cfg_valid_i = 1'b0;
    cfg_bus.cfg_div_i   = '0;

    // 1: free-running strobes at reset divisors.
    do_reset("t1");
    for (int k = 1; k <= 24; k++) begin
      step();
      check_eq($sformatf("t1_baud_e%0d", k), 32'(baud_tick_o), 32'(k % 6 == 0));
      check_eq($sformatf("t1_tick_e%0d", k), 32'(tick_o), 32'(k % 5 == 0));
      check_eq($sformatf("t1_sec_e%0d", k),  32'(sec_tick_o), 32'(k % 20 == 0));
    end
    check_eq("t1_cur_div", 32'(cfg_bus.cur_div_o), 6);

    // 2: divisor 3 offered at bcnt=2; accepted at edge 3, applied at edge 6.
    do_reset("t2");
    for (int k = 1; k <= 15; k++) begin
      step();
      check_eq($sformatf("t2_baud_e%0d", k), 32'(baud_tick_o),
               32'(k == 6 || (k > 6 && (k - 6) % 3 == 0)));
      check_eq($sformatf("t2_ready_e%0d", k), 32'(cfg_bus.cfg_ready_o), 32'(k < 3 || k >= 6));
      check_eq($sformatf("t2_cur_e%0d", k), 32'(cfg_bus.cur_div_o), (k >= 6) ? 3 : 6);
      check_eq($sformatf("t2_err_e%0d", k), 32'(cfg_bus.cfg_err_o), 0);
      if (k == 2) offer(16'd3);
      if (k == 3) drop_offer();
    end

    // 3: divisor 0 is clamped to 2 with a one-cycle error pulse.
    do_reset("t3");
    offer(16'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) drop_offer();
      check_eq($sformatf("t3_err_e%0d", k), 32'(cfg_bus.cfg_err_o), 32'(k == 1));
      check_eq($sformatf("t3_baud_e%0d", k), 32'(baud_tick_o),
               32'(k == 6 || (k > 6 && k % 2 == 0)));
      check_eq($sformatf("t3_cur_e%0d", k), 32'(cfg_bus.cur_div_o), (k >= 6) ? 2 : 6);
      check_eq($sformatf("t3_ready_e%0d", k), 32'(cfg_bus.cfg_ready_o), 32'(k >= 6));
    end

    // 4: en_i low for edges 4..10 while divisor 3 is pending.
    do_reset("t4");
    offer(16'd3);
    for (int k = 1; k <= 20; k++) begin
      int  e;
      bit  on;
      step();
      if (k == 1) drop_offer();
      on = !(k >= 4 && k <= 10);
      e  = (k <= 3) ? k : ((k <= 10) ? 3 : k - 7);
      check_eq($sformatf("t4_baud_e%0d", k), 32'(baud_tick_o),
               32'(on && (e == 6 || (e > 6 && (e - 6) % 3 == 0))));
      check_eq($sformatf("t4_tick_e%0d", k), 32'(tick_o), 32'(on && e % 5 == 0));
      check_eq($sformatf("t4_ready_e%0d", k), 32'(cfg_bus.cfg_ready_o), 32'(k >= 13));
      check_eq($sformatf("t4_state_e%0d", k), 32'(dbg_state_o),
               (k >= 13) ? 32'(CFG_IDLE) : 32'(CFG_PENDING));
      if (k == 3)  en_i = 1'b0;
      if (k == 10) en_i = 1'b1;
    end
    check_eq("t4_cur_div", 32'(cfg_bus.cur_div_o), 3);

    // 5: sync_i on edge 20, where tick and sec would both fire.
    do_reset("t5");
    for (int k = 1; k <= 42; k++) begin
      step();
      sync_i = (k == 19);
      check_eq($sformatf("t5_tick_e%0d", k), 32'(tick_o), 32'(k % 5 == 0 && k != 20));
      check_eq($sformatf("t5_sec_e%0d", k),  32'(sec_tick_o), 32'(k == 40));
      check_eq($sformatf("t5_baud_e%0d", k), 32'(baud_tick_o), 32'(k % 6 == 0));
    end

    // 6: asynchronous reset while divisor 3 is pending drops it.
    do_reset("t6");
    offer(16'd3);
    step();
    drop_offer();
    step();
    step();
    check_eq("t6_pending_ready", 32'(cfg_bus.cfg_ready_o), 0);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("t6_async_cur",   32'(cfg_bus.cur_div_o), 6);
    check_eq("t6_async_ready", 32'(cfg_bus.cfg_ready_o), 1);
    check_eq("t6_async_state", 32'(dbg_state_o), 32'(CFG_IDLE));
    check_eq("t6_async_baud",  32'(baud_tick_o), 0);
    step();
    rst_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq($sformatf("t6_baud_e%0d", k), 32'(baud_tick_o), 32'(k % 6 == 0));
      check_eq($sformatf("t6_tick_e%0d", k), 32'(tick_o), 32'(k % 5 == 0));
      check_eq($sformatf("t6_cur_e%0d", k), 32'(cfg_bus.cur_div_o), 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
